// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the shared memory bus and
// the arbiter. The arbiter uses the master view; the environment uses the slave view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_ack_o;
    logic [DATA_W-1:0]     if_data_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [DATA_W/8-1:0]   d_sel_i;
    logic [ADDR_W-1:0]     d_addr_i;
    logic [DATA_W-1:0]     d_data_i;
    logic                  d_ack_o;
    logic [DATA_W-1:0]     d_data_o;

    logic                  bus_cyc_o;
    logic                  bus_we_o;
    logic [DATA_W/8-1:0]   bus_sel_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W-1:0]     bus_data_o;
    logic [DATA_W-1:0]     bus_data_i;
    logic                  bus_ack_i;

    logic                  stall_req_o;
    logic                  err_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        input  bus_data_i, bus_ack_i,
        output if_ack_o, if_data_o, d_ack_o, d_data_o,
        output bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        output stall_req_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        output bus_data_i, bus_ack_i,
        input  if_ack_o, if_data_o, d_ack_o, d_data_o,
        input  bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        input  stall_req_o, err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data
// access: one transaction at a time, data priority with a fetch starvation guard.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);
    localparam int SEL_W    = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [7:0]          TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic                 r_cyc, w_cyc_nx;
    logic                 r_we, w_we_nx;
    logic [SEL_W-1:0]     r_sel, w_sel_nx;
    logic [ADDR_W-1:0]    r_addr, w_addr_nx;
    logic [DATA_W-1:0]    r_wdata, w_wdata_nx;
    logic                 r_if_ack, w_if_ack_nx;
    logic [DATA_W-1:0]    r_if_data, w_if_data_nx;
    logic                 r_d_ack, w_d_ack_nx;
    logic [DATA_W-1:0]    r_d_data, w_d_data_nx;
    logic                 r_err, w_err_nx;
    logic [STREAK_W-1:0]  r_streak, w_streak_nx;
    logic [7:0]           r_tmo, w_tmo_nx;

    logic                 w_if_elig;
    logic                 w_d_elig;
    logic                 w_pick_if;
    logic                 w_done;
    logic                 w_tmo_hit;

    // A requester acked this cycle is still holding req; masking it avoids a replay.
    assign w_if_elig = bus.if_req_i & ~r_if_ack;
    assign w_d_elig  = bus.d_req_i  & ~r_d_ack;
    assign w_pick_if = w_if_elig & (~w_d_elig | (r_streak == STREAK_MAX));
    assign w_done    = bus.bus_ack_i;
    assign w_tmo_hit = ~bus.bus_ack_i & (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_if_ack  <= 1'b0;
            r_if_data <= '0;
            r_d_ack   <= 1'b0;
            r_d_data  <= '0;
            r_err     <= 1'b0;
            r_streak  <= '0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cyc     <= w_cyc_nx;
            r_we      <= w_we_nx;
            r_sel     <= w_sel_nx;
            r_addr    <= w_addr_nx;
            r_wdata   <= w_wdata_nx;
            r_if_ack  <= w_if_ack_nx;
            r_if_data <= w_if_data_nx;
            r_d_ack   <= w_d_ack_nx;
            r_d_data  <= w_d_data_nx;
            r_err     <= w_err_nx;
            r_streak  <= w_streak_nx;
            r_tmo     <= w_tmo_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cyc_nx     = r_cyc;
        w_we_nx      = r_we;
        w_sel_nx     = r_sel;
        w_addr_nx    = r_addr;
        w_wdata_nx   = r_wdata;
        w_if_ack_nx  = 1'b0;
        w_if_data_nx = r_if_data;
        w_d_ack_nx   = 1'b0;
        w_d_data_nx  = r_d_data;
        w_err_nx     = 1'b0;
        w_streak_nx  = r_streak;
        w_tmo_nx     = r_tmo;

        unique case (r_state)
            IDLE: begin
                if (w_pick_if) begin
                    w_state_nx  = BUSY_I;
                    w_cyc_nx    = 1'b1;
                    w_we_nx     = 1'b0;
                    w_sel_nx    = '1;
                    w_addr_nx   = bus.if_addr_i;
                    w_wdata_nx  = '0;
                    w_streak_nx = '0;
                    w_tmo_nx    = '0;
                end else if (w_d_elig) begin
                    w_state_nx  = BUSY_D;
                    w_cyc_nx    = 1'b1;
                    w_we_nx     = bus.d_we_i;
                    w_sel_nx    = bus.d_sel_i;
                    w_addr_nx   = bus.d_addr_i;
                    w_wdata_nx  = bus.d_data_i;
                    w_tmo_nx    = '0;
                    // The streak only counts data wins that actually made fetch wait.
                    if (!w_if_elig)
                        w_streak_nx = '0;
                    else if (r_streak != STREAK_MAX)
                        w_streak_nx = r_streak + STREAK_W'(1);
                end
            end

            BUSY_I, BUSY_D: begin
                if (w_done || w_tmo_hit) begin
                    w_state_nx = IDLE;
                    w_cyc_nx   = 1'b0;
                    w_err_nx   = w_tmo_hit;
                    if (r_state == BUSY_I) begin
                        w_if_ack_nx  = 1'b1;
                        w_if_data_nx = w_done ? bus.bus_data_i : '0;
                    end else begin
                        w_d_ack_nx   = 1'b1;
                        w_d_data_nx  = w_done ? bus.bus_data_i : '0;
                    end
                end else begin
                    w_tmo_nx = r_tmo + 8'd1;
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_cyc_nx   = 1'b0;
            end
        endcase
    end

    assign bus.bus_cyc_o  = r_cyc;
    assign bus.bus_we_o   = r_we;
    assign bus.bus_sel_o  = r_sel;
    assign bus.bus_addr_o = r_addr;
    assign bus.bus_data_o = r_wdata;
    assign bus.if_ack_o   = r_if_ack;
    assign bus.if_data_o  = r_if_data;
    assign bus.d_ack_o    = r_d_ack;
    assign bus.d_data_o   = r_d_data;
    assign bus.err_o      = r_err;

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign bus.stall_req_o = rst & ((bus.if_req_i & ~r_if_ack) | (bus.d_req_i & ~r_d_ack));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the memory acks in the
// first cycle bus_cyc_o is high unless memEn is cleared.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;
    logic memEn;
    logic strayAck;
    int   nCompared;
    int   nMismatched;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bif.bus_ack_i = (memEn & bif.bus_cyc_o) | strayAck;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        memEn = 1'b1;
        strayAck = 1'b0;
        bif.if_req_i = 1'b0;  bif.if_addr_i = '0;
        bif.d_req_i = 1'b0;   bif.d_we_i = 1'b0;  bif.d_sel_i = '0;
        bif.d_addr_i = '0;    bif.d_data_i = '0;  bif.bus_data_i = '0;
        tick(); tick();
        nCompared++;
        if (bif.bus_cyc_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cyc got %b want 0", bif.bus_cyc_o); end
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o, bif.err_o, bif.stall_req_o} !== 4'b0000) begin
            nMismatched++; $display("[TB] FAIL reset_flags got %b want 0000", {bif.if_ack_o, bif.d_ack_o, bif.err_o, bif.stall_req_o});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        bif.bus_data_i = 32'h3C011234;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h100;
        #1;
        nCompared++;
        if (bif.stall_req_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL fetch_stall_req got %b want 1", bif.stall_req_o); end
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_we_o, bif.bus_sel_o} !== 6'b10_1111) begin
            nMismatched++; $display("[TB] FAIL fetch_grant got %b want 101111", {bif.bus_cyc_o, bif.bus_we_o, bif.bus_sel_o});
        end
        nCompared++;
        if (bif.bus_addr_o !== 32'h100) begin nMismatched++; $display("[TB] FAIL fetch_addr got %h want 00000100", bif.bus_addr_o); end
        nCompared++;
        if ({bif.if_ack_o, bif.stall_req_o} !== 2'b01) begin nMismatched++; $display("[TB] FAIL fetch_busy got %b want 01", {bif.if_ack_o, bif.stall_req_o}); end
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.bus_cyc_o, bif.stall_req_o} !== 3'b100) begin
            nMismatched++; $display("[TB] FAIL fetch_ack got %b want 100", {bif.if_ack_o, bif.bus_cyc_o, bif.stall_req_o});
        end
        nCompared++;
        if (bif.if_data_o !== 32'h3C011234) begin nMismatched++; $display("[TB] FAIL fetch_data got %h want 3c011234", bif.if_data_o); end
        bif.if_req_i = 1'b0;
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.bus_cyc_o} !== 2'b00) begin nMismatched++; $display("[TB] FAIL fetch_after got %b want 00", {bif.if_ack_o, bif.bus_cyc_o}); end
        nCompared++;
        if (bif.if_data_o !== 32'h3C011234) begin nMismatched++; $display("[TB] FAIL fetch_data_hold got %h want 3c011234", bif.if_data_o); end
    endtask

    task automatic test_simultaneous();
        bif.bus_data_i = 32'h11112222;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h104;
        bif.d_req_i = 1'b1;  bif.d_we_i = 1'b1; bif.d_sel_i = 4'b0011;
        bif.d_addr_i = 32'h200; bif.d_data_i = 32'hDEADBEEF;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_we_o, bif.bus_sel_o} !== 6'b11_0011) begin
            nMismatched++; $display("[TB] FAIL sim_data_grant got %b want 110011", {bif.bus_cyc_o, bif.bus_we_o, bif.bus_sel_o});
        end
        nCompared++;
        if ({bif.bus_addr_o, bif.bus_data_o} !== {32'h200, 32'hDEADBEEF}) begin
            nMismatched++; $display("[TB] FAIL sim_data_bus got %h %h want 00000200 deadbeef", bif.bus_addr_o, bif.bus_data_o);
        end
        tick();
        nCompared++;
        if ({bif.d_ack_o, bif.if_ack_o, bif.bus_cyc_o} !== 3'b100) begin
            nMismatched++; $display("[TB] FAIL sim_d_ack got %b want 100", {bif.d_ack_o, bif.if_ack_o, bif.bus_cyc_o});
        end
        nCompared++;
        if (bif.d_data_o !== 32'h11112222) begin nMismatched++; $display("[TB] FAIL sim_write_data got %h want 11112222", bif.d_data_o); end
        bif.d_req_i = 1'b0;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_we_o, bif.bus_addr_o} !== {2'b10, 32'h104}) begin
            nMismatched++; $display("[TB] FAIL sim_fetch_grant got %b %h want 10 00000104", {bif.bus_cyc_o, bif.bus_we_o}, bif.bus_addr_o);
        end
        nCompared++;
        if ({bif.d_ack_o, bif.if_ack_o} !== 2'b00) begin nMismatched++; $display("[TB] FAIL sim_no_double got %b want 00", {bif.d_ack_o, bif.if_ack_o}); end
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o} !== 2'b10) begin nMismatched++; $display("[TB] FAIL sim_if_ack got %b want 10", {bif.if_ack_o, bif.d_ack_o}); end
        bif.if_req_i = 1'b0;
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o, bif.bus_cyc_o} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL sim_quiet got %b want 000", {bif.if_ack_o, bif.d_ack_o, bif.bus_cyc_o});
        end
    endtask

    // Fetch withdraws only during data ack cycles, so every data grant is one it lost.
    task automatic test_starvation();
        bif.bus_data_i = 32'hCAFE0000;
        bif.if_addr_i = 32'h400;
        bif.d_req_i = 1'b1; bif.d_we_i = 1'b0; bif.d_sel_i = 4'b1111;
        bif.d_addr_i = 32'h300; bif.d_data_i = '0;
        for (int k = 0; k < 4; k++) begin
            bif.if_req_i = 1'b1;
            tick();
            nCompared++;
            if ({bif.bus_cyc_o, bif.bus_addr_o} !== {1'b1, 32'h300}) begin
                nMismatched++; $display("[TB] FAIL starve_d_grant%0d got %b %h want 1 00000300", k, bif.bus_cyc_o, bif.bus_addr_o);
            end
            tick();
            nCompared++;
            if ({bif.d_ack_o, bif.if_ack_o} !== 2'b10) begin nMismatched++; $display("[TB] FAIL starve_d_ack%0d got %b want 10", k, {bif.d_ack_o, bif.if_ack_o}); end
            bif.if_req_i = 1'b0;
            tick();
        end
        bif.if_req_i = 1'b1;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_we_o, bif.bus_addr_o} !== {2'b10, 32'h400}) begin
            nMismatched++; $display("[TB] FAIL starve_f_grant got %b %h want 10 00000400", {bif.bus_cyc_o, bif.bus_we_o}, bif.bus_addr_o);
        end
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o} !== 2'b10) begin nMismatched++; $display("[TB] FAIL starve_f_ack got %b want 10", {bif.if_ack_o, bif.d_ack_o}); end
        bif.if_req_i = 1'b0;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_addr_o} !== {1'b1, 32'h300}) begin
            nMismatched++; $display("[TB] FAIL starve_d_resume got %b %h want 1 00000300", bif.bus_cyc_o, bif.bus_addr_o);
        end
        tick();
        nCompared++;
        if (bif.d_ack_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL starve_d_resume_ack got %b want 1", bif.d_ack_o); end
        bif.d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        memEn = 1'b0;
        bif.d_req_i = 1'b1; bif.d_we_i = 1'b0; bif.d_addr_i = 32'h500;
        tick();
        nCompared++;
        if (bif.bus_cyc_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL tmo_grant got %b want 1", bif.bus_cyc_o); end
        for (int i = 1; i < 8; i++) begin
            tick();
            nCompared++;
            if ({bif.bus_cyc_o, bif.err_o, bif.d_ack_o} !== 3'b100) begin
                nMismatched++; $display("[TB] FAIL tmo_wait%0d got %b want 100", i, {bif.bus_cyc_o, bif.err_o, bif.d_ack_o});
            end
        end
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.err_o, bif.d_ack_o} !== 3'b011) begin
            nMismatched++; $display("[TB] FAIL tmo_fire got %b want 011", {bif.bus_cyc_o, bif.err_o, bif.d_ack_o});
        end
        nCompared++;
        if (bif.d_data_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL tmo_data got %h want 00000000", bif.d_data_o); end
        bif.d_req_i = 1'b0;
        tick();
        nCompared++;
        if ({bif.err_o, bif.d_ack_o} !== 2'b00) begin nMismatched++; $display("[TB] FAIL tmo_pulse got %b want 00", {bif.err_o, bif.d_ack_o}); end
        memEn = 1'b1;
        bif.bus_data_i = 32'h55AA55AA;
        bif.d_req_i = 1'b1;
        tick();
        tick();
        nCompared++;
        if ({bif.d_ack_o, bif.err_o, bif.d_data_o} !== {2'b10, 32'h55AA55AA}) begin
            nMismatched++; $display("[TB] FAIL tmo_recover got %b %h want 10 55aa55aa", {bif.d_ack_o, bif.err_o}, bif.d_data_o);
        end
        bif.d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        memEn = 1'b0;
        bif.d_req_i = 1'b1; bif.d_addr_i = 32'h600;
        tick();
        nCompared++;
        if (bif.bus_cyc_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_busy got %b want 1", bif.bus_cyc_o); end
        #2 rst = 1'b0;
        #1;
        nCompared++;
        if ({bif.bus_cyc_o, bif.d_ack_o, bif.if_ack_o, bif.stall_req_o} !== 4'b0000) begin
            nMismatched++; $display("[TB] FAIL rmid_async got %b want 0000", {bif.bus_cyc_o, bif.d_ack_o, bif.if_ack_o, bif.stall_req_o});
        end
        tick(); tick();
        memEn = 1'b1;
        bif.bus_data_i = 32'h0BADF00D;
        rst = 1'b1;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_addr_o} !== {1'b1, 32'h600}) begin
            nMismatched++; $display("[TB] FAIL rmid_regrant got %b %h want 1 00000600", bif.bus_cyc_o, bif.bus_addr_o);
        end
        tick();
        nCompared++;
        if ({bif.d_ack_o, bif.d_data_o} !== {1'b1, 32'h0BADF00D}) begin
            nMismatched++; $display("[TB] FAIL rmid_ack got %b %h want 1 0badf00d", bif.d_ack_o, bif.d_data_o);
        end
        bif.d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        strayAck = 1'b1;
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o, bif.err_o, bif.bus_cyc_o} !== 4'b0000) begin
            nMismatched++; $display("[TB] FAIL stray_outputs got %b want 0000", {bif.if_ack_o, bif.d_ack_o, bif.err_o, bif.bus_cyc_o});
        end
        strayAck = 1'b0;
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.d_ack_o, bif.bus_cyc_o} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL stray_after got %b want 000", {bif.if_ack_o, bif.d_ack_o, bif.bus_cyc_o});
        end
        bif.bus_data_i = 32'h12345678;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h700;
        tick();
        nCompared++;
        if ({bif.bus_cyc_o, bif.bus_addr_o} !== {1'b1, 32'h700}) begin
            nMismatched++; $display("[TB] FAIL stray_idle_grant got %b %h want 1 00000700", bif.bus_cyc_o, bif.bus_addr_o);
        end
        tick();
        nCompared++;
        if ({bif.if_ack_o, bif.if_data_o} !== {1'b1, 32'h12345678}) begin
            nMismatched++; $display("[TB] FAIL stray_fetch_ack got %b %h want 1 12345678", bif.if_ack_o, bif.if_data_o);
        end
        bif.if_req_i = 1'b0;
        tick();
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
